// File: rtl/handshake_wait_ctrl.sv
// handshake_wait_ctrl: arms a sequence detector with the expected handshake PID, waits with timeout, and drives resend/fail decisions
module handshake_wait_ctrl #(
  parameter logic [15:0] TIMEOUT_CYC = 16'd200,
  parameter logic [1:0]  MAX_RETRY   = 2'd3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       hs_start,
  input  logic [7:0] exp_pid,
  input  logic       hs_abort,
  input  logic       rx_bit,
  input  logic       rx_bit_valid,
  output logic [7:0] det_seq,
  output logic       det_bit,
  output logic       det_bit_valid,
  input  logic       det_hit,
  output logic       busy,
  output logic       hs_done,
  output logic       retry_req,
  output logic       hs_fail,
  output logic [1:0] retry_cnt
);
  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ARM    = 2'd1;
  localparam logic [1:0] S_WAIT   = 2'd2;
  localparam logic [1:0] S_RESEND = 2'd3;
  logic [1:0]  state;
  logic [15:0] tcnt;
  logic        timeout;
  logic        late;
  assign timeout       = tcnt == TIMEOUT_CYC - 16'd1;
  assign late          = retry_req | hs_fail;
  assign det_bit       = rx_bit;
  assign det_bit_valid = rx_bit_valid && (state == S_WAIT);
  assign busy          = state != S_IDLE;
  // handshake FSM: arm, wait with timeout, resend or fail; a hit one cycle after a timeout ends the transaction quietly
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_IDLE;
      det_seq   <= 8'h00;
      tcnt      <= 16'd0;
      retry_cnt <= 2'd0;
      hs_done   <= 1'b0;
      retry_req <= 1'b0;
      hs_fail   <= 1'b0;
    end else begin
      hs_done   <= 1'b0;
      retry_req <= 1'b0;
      hs_fail   <= 1'b0;
      if (hs_abort) begin
        state <= S_IDLE;
      end else begin
        case (state)
          S_IDLE: if (hs_start) begin
            det_seq   <= exp_pid;
            retry_cnt <= 2'd0;
            state     <= S_ARM;
          end
          S_ARM: begin
            tcnt  <= 16'd0;
            state <= S_WAIT;
          end
          S_WAIT: begin
            tcnt <= tcnt + 16'd1;
            if (det_hit) begin
              hs_done <= 1'b1;
              state   <= S_IDLE;
            end else if (timeout && retry_cnt < MAX_RETRY) begin
              retry_req <= 1'b1;
              retry_cnt <= retry_cnt + 2'd1;
              state     <= S_RESEND;
            end else if (timeout) begin
              hs_fail <= 1'b1;
              state   <= S_IDLE;
            end
          end
          default: state <= (late && det_hit) ? S_IDLE : hs_start ? S_ARM : S_RESEND;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_handshake_wait_ctrl.sv
// tb_handshake_wait_ctrl: table vectors, directed corner sequences and a randomized run against a transaction-level model
module tb_handshake_wait_ctrl;
  localparam int TMO  = 16;
  localparam int MAXR = 3;

  logic       clk = 0, rst = 0, hs_start = 0, hs_abort = 0, rx_bit = 0, rx_bit_valid = 0;
  logic [7:0] exp_pid = 8'h00;
  logic       force_hit = 0, use_det = 1, chk_en = 0;
  logic [7:0] det_seq;
  logic       det_bit, det_bit_valid, det_hit, busy, hs_done, retry_req, hs_fail;
  logic [1:0] retry_cnt;
  int checks = 0, errors = 0;

  handshake_wait_ctrl #(.TIMEOUT_CYC(16'd16), .MAX_RETRY(2'd3)) dut (
    .clk(clk), .rst(rst), .hs_start(hs_start), .exp_pid(exp_pid), .hs_abort(hs_abort),
    .rx_bit(rx_bit), .rx_bit_valid(rx_bit_valid), .det_seq(det_seq), .det_bit(det_bit),
    .det_bit_valid(det_bit_valid), .det_hit(det_hit), .busy(busy), .hs_done(hs_done),
    .retry_req(retry_req), .hs_fail(hs_fail), .retry_cnt(retry_cnt));

  always #5 clk = ~clk;

  // behavioural sequence detector: LSB-first shift, registered hit, flushed whenever valid drops
  logic [7:0] dsh;
  int         dn;
  logic       det_q;
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      dsh <= 8'h00; dn <= 0; det_q <= 1'b0;
    end else if (det_bit_valid) begin
      dsh   <= {det_bit, dsh[7:1]};
      dn    <= dn + 1;
      det_q <= (dn >= 7) && ({det_bit, dsh[7:1]} == det_seq);
    end else begin
      dn <= 0; det_q <= 1'b0;
    end
  end
  assign det_hit = use_det ? det_q : force_hit;

  typedef struct {
    bit busy, armed, resend;
    int waited, retries;
    logic [7:0] seq;
    bit done, retry, fail;
  } model_t;
  model_t m;

  function automatic model_t step(model_t c, bit start, logic [7:0] pid, bit abort, bit hit);
    model_t n = c;
    bit late = c.retry | c.fail;
    n.done = 0; n.retry = 0; n.fail = 0;
    if (abort) begin
      n.busy = 0; n.armed = 0; n.resend = 0;
    end else if (!c.busy) begin
      if (start) begin n.busy = 1; n.armed = 1; n.seq = pid; n.retries = 0; end
    end else if (c.armed) begin
      n.armed = 0; n.waited = 0;
    end else if (c.resend) begin
      if (late && hit) begin n.busy = 0; n.resend = 0; end
      else if (start) begin n.resend = 0; n.armed = 1; end
    end else begin
      n.waited = c.waited + 1;
      if (hit) begin n.done = 1; n.busy = 0; end
      else if (n.waited == TMO) begin
        if (c.retries < MAXR) begin n.retry = 1; n.retries = c.retries + 1; n.resend = 1; end
        else begin n.fail = 1; n.busy = 0; end
      end
    end
    return n;
  endfunction

  always @(posedge clk or negedge rst)
    if (!rst) m <= '{default: 0};
    else      m <= step(m, hs_start, exp_pid, hs_abort, det_hit);

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // every cycle, all outputs against the model
  always @(negedge clk) if (chk_en && rst) begin
    check("model_busy", busy, m.busy);
    check("model_done", hs_done, m.done);
    check("model_retry", retry_req, m.retry);
    check("model_fail", hs_fail, m.fail);
    check("model_cnt", retry_cnt, m.retries);
    check("model_seq", det_seq, m.seq);
    check("model_dbv", det_bit_valid, rx_bit_valid && m.busy && !m.armed && !m.resend);
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic start_tx(input logic [7:0] p);
    hs_start = 1; exp_pid = p; tick();
    hs_start = 0; tick();
  endtask

  task automatic send_bits(input logic [7:0] p);
    for (int i = 0; i < 8; i++) begin
      rx_bit_valid = 1; rx_bit = p[i]; tick();
    end
    rx_bit_valid = 0;
  endtask

  task automatic wait_pulse(input int which, input int maxc, output int k);
    k = 0;
    do begin tick(); k++; end
    while (!(which == 0 ? hs_done : which == 1 ? retry_req : hs_fail) && k < maxc);
  endtask

  typedef struct {
    logic start; logic [7:0] pid; logic abort; logic hit;
    logic busy, done, retry, fail; logic [1:0] cnt; logic [7:0] seq;
  } vec_t;
  vec_t tbl[12];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int k, nd;
    logic b_at, c_at;
    tbl[0]  = '{1, 8'h3C, 0, 0, 1, 0, 0, 0, 2'd0, 8'h3C};
    tbl[1]  = '{0, 8'h00, 0, 0, 1, 0, 0, 0, 2'd0, 8'h3C};
    tbl[2]  = '{1, 8'hFF, 0, 0, 1, 0, 0, 0, 2'd0, 8'h3C};
    tbl[3]  = '{0, 8'h00, 0, 1, 0, 1, 0, 0, 2'd0, 8'h3C};
    tbl[4]  = '{0, 8'h00, 0, 0, 0, 0, 0, 0, 2'd0, 8'h3C};
    tbl[5]  = '{1, 8'h11, 0, 0, 1, 0, 0, 0, 2'd0, 8'h11};
    tbl[6]  = '{0, 8'h00, 1, 0, 0, 0, 0, 0, 2'd0, 8'h11};
    tbl[7]  = '{1, 8'h22, 1, 0, 0, 0, 0, 0, 2'd0, 8'h11};
    tbl[8]  = '{1, 8'h33, 0, 0, 1, 0, 0, 0, 2'd0, 8'h33};
    tbl[9]  = '{0, 8'h00, 0, 0, 1, 0, 0, 0, 2'd0, 8'h33};
    tbl[10] = '{0, 8'h00, 1, 1, 0, 0, 0, 0, 2'd0, 8'h33};
    tbl[11] = '{0, 8'h00, 0, 0, 0, 0, 0, 0, 2'd0, 8'h33};

    rx_bit_valid = 1;
    repeat (3) tick();
    check("rst_busy", busy, 0);
    check("rst_seq", det_seq, 8'h00);
    check("rst_cnt", retry_cnt, 0);
    check("rst_pulses", {hs_done, retry_req, hs_fail}, 0);
    check("rst_dbv", det_bit_valid, 0);
    rx_bit_valid = 0;
    rst = 1; chk_en = 1;
    tick();

    use_det = 0;
    foreach (tbl[i]) begin
      hs_start = tbl[i].start; exp_pid = tbl[i].pid; hs_abort = tbl[i].abort; force_hit = tbl[i].hit;
      tick(); #1;
      check($sformatf("tbl%0d_busy", i), busy, tbl[i].busy);
      check($sformatf("tbl%0d_pulses", i), {hs_done, retry_req, hs_fail}, {tbl[i].done, tbl[i].retry, tbl[i].fail});
      check($sformatf("tbl%0d_cnt", i), retry_cnt, tbl[i].cnt);
      check($sformatf("tbl%0d_seq", i), det_seq, tbl[i].seq);
    end
    hs_start = 0; hs_abort = 0; force_hit = 0; use_det = 1;
    tick();

    start_tx(8'hD2);
    send_bits(8'hD2);
    nd = 0; b_at = 1; c_at = 1;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (hs_done) begin nd++; b_at = busy; c_at = (retry_cnt != 0); end
    end
    check("d2_done_count", nd, 1);
    check("d2_busy_at_done", b_at, 0);
    check("d2_cnt_nonzero", c_at, 0);

    start_tx(8'h5A);
    for (int r = 1; r <= 3; r++) begin
      wait_pulse(1, 40, k);
      check($sformatf("retry%0d_delay", r), k, TMO);
      check($sformatf("retry%0d_cnt", r), retry_cnt, r);
      start_tx(8'h5A);
    end
    wait_pulse(2, 40, k);
    check("fail_delay", k, TMO);
    check("fail_no_retry", retry_req, 0);
    check("fail_cnt", retry_cnt, 3);
    check("fail_busy", busy, 0);
    tick();

    start_tx(8'h96);
    repeat (7) tick();
    send_bits(8'h96);
    tick();
    check("tie_done", hs_done, 1);
    check("tie_retry", retry_req, 0);
    check("tie_cnt", retry_cnt, 0);
    tick();

    start_tx(8'h96);
    repeat (8) tick();
    send_bits(8'h96);
    check("late_retry", retry_req, 1);
    check("late_hit_seen", det_hit, 1);
    tick();
    check("late_no_done", hs_done, 0);
    check("late_cnt", retry_cnt, 1);
    tick();

    start_tx(8'hC3);
    for (int i = 0; i < 4; i++) begin rx_bit_valid = 1; rx_bit = exp_pid[i]; tick(); end
    hs_abort = 1; rx_bit = exp_pid[4]; tick();
    hs_abort = 0;
    check("abort_busy", busy, 0);
    check("abort_pulses", {hs_done, retry_req, hs_fail}, 0);
    check("abort_dbv", det_bit_valid, 0);
    rx_bit_valid = 0; tick();
    check("abort_det_idle", det_hit, 0);
    start_tx(8'hC3);
    send_bits(8'hC3);
    tick();
    check("abort_fresh_done", hs_done, 1);
    tick();

    start_tx(8'h3C);
    wait_pulse(1, 40, k);
    start_tx(8'h3C);
    wait_pulse(1, 40, k);
    check("pre_rst_cnt", retry_cnt, 2);
    #3 rst = 0;
    #1;
    check("arst_busy", busy, 0);
    check("arst_seq", det_seq, 8'h00);
    check("arst_cnt", retry_cnt, 0);
    check("arst_pulses", {hs_done, retry_req, hs_fail}, 0);
    check("arst_dbv", det_bit_valid, 0);
    #2 rst = 1;
    tick();
    check("post_rst_idle", busy, 0);
    hs_start = 1; exp_pid = 8'h5A; tick();
    check("arm_seq", det_seq, 8'h5A);
    exp_pid = 8'hFF; tick();
    check("arm_ignore_seq", det_seq, 8'h5A);
    tick();
    check("wait_ignore_seq", det_seq, 8'h5A);
    check("wait_busy", busy, 1);
    hs_start = 0; hs_abort = 1; tick();
    hs_abort = 0; tick();

    begin
      logic [7:0] pids [4] = '{8'hD2, 8'h4B, 8'hA5, 8'h1E};
      int fi = 0;
      for (int c = 0; c < 3000; c++) begin
        hs_start     = ($urandom % 6) == 0;
        exp_pid      = pids[$urandom % 4];
        hs_abort     = ($urandom % 80) == 0;
        rx_bit_valid = ($urandom % 8) != 0;
        rx_bit       = (($urandom % 5) != 0) ? m.seq[fi] : 1'($urandom % 2);
        if (rx_bit_valid) fi = (fi + 1) % 8;
        tick();
      end
    end
    hs_start = 0; hs_abort = 0; rx_bit_valid = 0;
    repeat (2) tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
